cmp_rr_arbiter: RTL
===================

Name: cmp_rr_arbiter

Overview:
- Shares one N-bit magnitude comparator among N_REQ requesters.
- Round-robin arbiter grants one requester per transaction and latches its operand pair.
- Comparison is performed in a registered stage; the result is returned with the requester ID under a valid/ready handshake.
- Sits between client blocks (sorters, min/max trackers) and the single comparator datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits.
- ID_W, 2, requester ID width; must be >= clog2(N_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request per requester; held high with operands stable until granted.
- a_in  in  N_REQ*WIDTH  flattened A operands; requester i uses bits [i*WIDTH +: WIDTH].
- b_in  in  N_REQ*WIDTH  flattened B operands, same packing.
- gnt  out  N_REQ  one-hot grant, combinational; operands transfer on the edge where req[i]&gnt[i].
- busy  out  1  high in CMP or RESP.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_id  out  ID_W  index of the requester that owns the result.
- lesser, greater, equal  out  1 each  result flags (A<B, A>B, A==B), unsigned, exactly one high while res_valid.
- txn_count  out  16  accepted-transaction count (optional feature).
- eq_count  out  16  count of equal results (optional feature).

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; rr pointer = 0.
  - res_valid, lesser, greater, equal, res_id, busy, gnt all 0; latched operands cleared.
  - Any in-flight transaction is dropped silently.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - gnt is one-hot to the first asserted req at or after the rr pointer, wrapping modulo N_REQ. gnt = 0 if req = 0.
  - On a clock edge with a grant: latch a_in/b_in slices and the ID, set ptr = (granted+1) mod N_REQ, go to CMP.
- CMP:
  - gnt = 0.
  - Compare latched A and B unsigned; register lesser/greater/equal and res_id.
  - Go to RESP.
- RESP:
  - res_valid = 1; flags and res_id held stable.
  - On res_ready = 1: clear res_valid and go to IDLE.
  - No new grant is issued in the same cycle as the res_ready acceptance.
- Timing:
  - Latency from grant edge to res_valid high is 2 edges.
  - Minimum spacing is 3 cycles per transaction.
- Boundary conditions:
  - req dropped before its grant: no transaction.
  - req changing while in CMP/RESP: ignored.
  - All req high: grants rotate 0,1,2,3,0...
  - Single requester repeatedly: served every transaction; the pointer wraps past it back to it.
  - res_ready held high continuously: RESP lasts exactly 1 cycle.
  - res_ready low: RESP holds indefinitely and no further grants are issued.
  - Flags are mutually exclusive; all flags are 0 whenever res_valid = 0.

Optional Feature:
- Macro: CMP_STATS_EN.
- Defined:
  - txn_count increments on every grant edge, saturating at 16'hFFFF.
  - eq_count increments on entry to RESP with equal = 1, saturating at 16'hFFFF.
  - Both reset to 0 on rst.
- Undefined: the counter logic is not built; both ports are driven constant 0.

Test Plan:
- Reset mid-transaction: assert rst while in CMP -> all outputs 0 immediately, next req0 is granted from IDLE with ptr = 0.
- Single transaction: req0 with a = 111, b = 250, res_ready = 1 -> gnt = 0001 for one cycle; 2 edges later res_valid = 1, res_id = 0, lesser = 1; 1 cycle later res_valid = 0.
- Round-robin: req = 1111 held, operand pairs (147,103), (199,220), (255,255), (85,25) -> res_id sequence 0,1,2,3,0 with flags greater, lesser, equal, greater.
- Backpressure: req1 with a = 169, b = 169, res_ready low for 5 cycles -> res_valid, equal = 1, res_id = 1 stable throughout; gnt stays 0 despite req2 high; req2 is granted in the IDLE cycle after acceptance.
- Fairness skip: ptr = 2, req = 1001 -> grant goes to 3, then 0.
- CMP_STATS_EN: run pairs (79,74), (96,96), (21,50), (96,96) -> txn_count = 4, eq_count = 2; without the macro both read 0.

Source files
------------

// File: rtl/cmp_rr_arbiter.sv
// cmp_rr_arbiter: round-robin access to one shared unsigned magnitude comparator.
// A granted requester's operand pair is latched, compared in a registered
// stage, and the result is returned with the requester ID over valid/ready.
// Optional statistics counters are built when CMP_STATS_EN is defined;
// otherwise txn_count and eq_count are tied to zero.
module cmp_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic                   lesser,
  output logic                   greater,
  output logic                   equal,
  output logic [15:0]            txn_count,
  output logic [15:0]            eq_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   ptr_nx_s;
  logic [ID_W-1:0]   id_r;
  logic [ID_W-1:0]   res_id_r;
  logic [ID_W-1:0]   gnt_id_s;
  logic [N_REQ-1:0]  gnt_s;
  logic              found_s;
  int                idx_s;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              lesser_r;
  logic              greater_r;
  logic              equal_r;
  logic              res_valid_r;
  logic              busy_r;

  // Round-robin pick: first asserted request at or after the pointer, only in IDLE and out of reset
  always_comb begin
    gnt_s    = '0;
    gnt_id_s = '0;
    found_s  = 1'b0;
    idx_s    = 0;
    if ((state_r == IDLE) && !rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx_s = int'(ptr_r) + k;
        if (idx_s >= N_REQ) begin
          idx_s = idx_s - N_REQ;
        end else begin
          idx_s = idx_s;
        end
        if (!found_s && req[idx_s]) begin
          found_s       = 1'b1;
          gnt_s[idx_s]  = 1'b1;
          gnt_id_s      = idx_s[ID_W-1:0];
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  assign ptr_nx_s = (gnt_id_s == ID_W'(N_REQ - 1)) ? '0 : (gnt_id_s + ID_W'(1));

  // Next-state logic for the IDLE -> CMP -> RESP transaction sequence
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nx_s = CMP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CMP: state_nx_s = RESP;
      RESP: begin
        if (res_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand latch on grant, registered compare, and result hold until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r       <= '0;
      id_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      res_id_r    <= '0;
      lesser_r    <= 1'b0;
      greater_r   <= 1'b0;
      equal_r     <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            a_r    <= a_in[int'(gnt_id_s)*WIDTH +: WIDTH];
            b_r    <= b_in[int'(gnt_id_s)*WIDTH +: WIDTH];
            id_r   <= gnt_id_s;
            ptr_r  <= ptr_nx_s;
            busy_r <= 1'b1;
          end
        end
        CMP: begin
          res_id_r    <= id_r;
          lesser_r    <= (a_r < b_r);
          greater_r   <= (a_r > b_r);
          equal_r     <= (a_r == b_r);
          res_valid_r <= 1'b1;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            lesser_r    <= 1'b0;
            greater_r   <= 1'b0;
            equal_r     <= 1'b0;
            res_id_r    <= '0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          lesser_r    <= 1'b0;
          greater_r   <= 1'b0;
          equal_r     <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMP_STATS_EN
  logic [15:0] txn_cnt_r;
  logic [15:0] eq_cnt_r;

  // Saturating counts of accepted grants and of equal results entering RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt_r <= 16'h0000;
      eq_cnt_r  <= 16'h0000;
    end else begin
      if ((state_r == IDLE) && found_s && (txn_cnt_r != 16'hFFFF)) begin
        txn_cnt_r <= txn_cnt_r + 16'h0001;
      end
      if ((state_r == CMP) && (a_r == b_r) && (eq_cnt_r != 16'hFFFF)) begin
        eq_cnt_r <= eq_cnt_r + 16'h0001;
      end
    end
  end

  assign txn_count = txn_cnt_r;
  assign eq_count  = eq_cnt_r;
`else
  assign txn_count = 16'h0000;
  assign eq_count  = 16'h0000;
`endif

  assign gnt       = gnt_s;
  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign lesser    = lesser_r;
  assign greater   = greater_r;
  assign equal     = equal_r;

endmodule
